// File: rtl/mpu_pkg.sv
// Shared definitions for the 5x5 int8 matrix multiplier and its operand loader.
package mpu_pkg;

   localparam int unsigned ELEM_W   = 8;
   localparam int unsigned DIM      = 5;
   localparam int unsigned MATRIX_W = ELEM_W * DIM * DIM;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned IDX_W    = $clog2(MATRIX_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      LOAD_B = 2'd2,
      HOLD   = 2'd3
   } loader_state_e;

   // Bit offset of element (row,col) in a row-major flattened matrix.
   function automatic int unsigned at(input logic [CNT_W-1:0] row,
                                      input logic [CNT_W-1:0] col);
      return ELEM_W * (32'(col) + DIM * 32'(row));
   endfunction

   // Sizes outside 1..DIM fall back to the full dimension.
   function automatic logic [CNT_W-1:0] clamp_size(input logic [CNT_W-1:0] n);
      if ((n == '0) || (n > CNT_W'(DIM))) begin
         return CNT_W'(DIM);
      end
      return n;
   endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row/column walker over an NxN window; col wraps at N-1 and carries into row.
module mpu_index_counter
   import mpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] size,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] row,
   output logic [CNT_W-1:0] col,
   output logic             last_c
);

   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] top_c;

   assign top_c  = CNT_W'(size - CNT_W'(1));
   assign last_c = (row_q == top_c) && (col_q == top_c);
   assign row    = row_q;
   assign col    = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (adv) begin
         if (col_q == top_c) begin
            col_d = '0;
            row_d = CNT_W'(row_q + CNT_W'(1));
         end else begin
            col_d = CNT_W'(col_q + CNT_W'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/mpu_operand_loader.sv
// Streams int8 elements into operand matrices A then B and holds them for the
// multiplier until it accepts them.
module mpu_operand_loader
   import mpu_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [2:0]          cfg_size,
   input  logic                clear,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [MATRIX_W-1:0] matrix_a,
   output logic [MATRIX_W-1:0] matrix_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy
);

   loader_state_e       state_q, state_d;
   logic [CNT_W-1:0]    size_q, size_d;
   logic [MATRIX_W-1:0] mat_a_q, mat_a_d;
   logic [MATRIX_W-1:0] mat_b_q, mat_b_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;

   logic                cnt_clr, cnt_adv, cnt_last;
   logic [CNT_W-1:0]    row, col;
   logic                beat_c;
   logic [IDX_W-1:0]    idx_c;

   mpu_index_counter u_idx (
      .clk    (clock),
      .rst_n  (reset_n),
      .size   (size_q),
      .clr    (cnt_clr),
      .adv    (cnt_adv),
      .row    (row),
      .col    (col),
      .last_c (cnt_last)
   );

   assign beat_c = in_valid & in_ready_q;
   assign idx_c  = IDX_W'(at(row, col));

   // Next-state, matrix writes and counter control; clear overrides everything.
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      mat_a_d = mat_a_q;
      mat_b_d = mat_b_q;
      cnt_clr = 1'b0;
      cnt_adv = 1'b0;

      if (clear) begin
         state_d = IDLE;
         mat_a_d = '0;
         mat_b_d = '0;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  size_d  = clamp_size(cfg_size);
                  mat_a_d = '0;
                  mat_b_d = '0;
                  cnt_clr = 1'b1;
                  state_d = LOAD_A;
               end
            end
            LOAD_A: begin
               if (beat_c) begin
                  mat_a_d[idx_c +: ELEM_W] = in_data;
                  if (cnt_last) begin
                     cnt_clr = 1'b1;
                     state_d = LOAD_B;
                  end else begin
                     cnt_adv = 1'b1;
                  end
               end
            end
            LOAD_B: begin
               if (beat_c) begin
                  mat_b_d[idx_c +: ELEM_W] = in_data;
                  if (cnt_last) begin
                     cnt_clr = 1'b1;
                     state_d = HOLD;
                  end else begin
                     cnt_adv = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
      out_valid_d = (state_d == HOLD);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         size_q      <= '0;
         mat_a_q     <= '0;
         mat_b_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         mat_a_q     <= mat_a_d;
         mat_b_q     <= mat_b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign matrix_a  = mat_a_q;
   assign matrix_b  = mat_b_q;

endmodule
